// File: rtl/axi_arb_2to1.sv
// Two-master, one-slave AXI4 arbiter: round-robin, one whole transaction granted at a time.
// Optional stall watchdog enabled by defining AXI_ARB_WDOG_EN.
module axi_arb_2to1 #(
    parameter int unsigned AXI_ADDR_W = 64,
    parameter int unsigned AXI_ID_W   = 8,
    parameter int unsigned AXI_DATA_W = 64,
    parameter int unsigned WDOG_LIMIT = 1024
) (
    input  logic                    aclk,
    input  logic                    rst,
    // Master 0 (instruction fetch)
    input  logic                    s0_arvalid,
    input  logic [AXI_ADDR_W-1:0]   s0_araddr,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    input  logic [AXI_ID_W-1:0]     s0_arid,
    output logic                    s0_arready,
    output logic                    s0_rvalid,
    output logic [AXI_DATA_W-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rlast,
    output logic [AXI_ID_W-1:0]     s0_rid,
    input  logic                    s0_rready,
    input  logic                    s0_awvalid,
    input  logic [AXI_ADDR_W-1:0]   s0_awaddr,
    input  logic [7:0]              s0_awlen,
    input  logic [2:0]              s0_awsize,
    input  logic [1:0]              s0_awburst,
    input  logic [AXI_ID_W-1:0]     s0_awid,
    output logic                    s0_awready,
    input  logic                    s0_wvalid,
    input  logic [AXI_DATA_W-1:0]   s0_wdata,
    input  logic [AXI_DATA_W/8-1:0] s0_wstrb,
    input  logic                    s0_wlast,
    output logic                    s0_wready,
    output logic                    s0_bvalid,
    output logic [1:0]              s0_bresp,
    output logic [AXI_ID_W-1:0]     s0_bid,
    input  logic                    s0_bready,
    // Master 1 (load/store)
    input  logic                    s1_arvalid,
    input  logic [AXI_ADDR_W-1:0]   s1_araddr,
    input  logic [7:0]              s1_arlen,
    input  logic [2:0]              s1_arsize,
    input  logic [1:0]              s1_arburst,
    input  logic [AXI_ID_W-1:0]     s1_arid,
    output logic                    s1_arready,
    output logic                    s1_rvalid,
    output logic [AXI_DATA_W-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rlast,
    output logic [AXI_ID_W-1:0]     s1_rid,
    input  logic                    s1_rready,
    input  logic                    s1_awvalid,
    input  logic [AXI_ADDR_W-1:0]   s1_awaddr,
    input  logic [7:0]              s1_awlen,
    input  logic [2:0]              s1_awsize,
    input  logic [1:0]              s1_awburst,
    input  logic [AXI_ID_W-1:0]     s1_awid,
    output logic                    s1_awready,
    input  logic                    s1_wvalid,
    input  logic [AXI_DATA_W-1:0]   s1_wdata,
    input  logic [AXI_DATA_W/8-1:0] s1_wstrb,
    input  logic                    s1_wlast,
    output logic                    s1_wready,
    output logic                    s1_bvalid,
    output logic [1:0]              s1_bresp,
    output logic [AXI_ID_W-1:0]     s1_bid,
    input  logic                    s1_bready,
    // Slave side
    output logic                    m_arvalid,
    output logic [AXI_ADDR_W-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic [AXI_ID_W-1:0]     m_arid,
    output logic                    m_arlock,
    output logic [3:0]              m_arcache,
    output logic [2:0]              m_arprot,
    output logic [3:0]              m_arqos,
    output logic [3:0]              m_arregion,
    input  logic                    m_arready,
    input  logic                    m_rvalid,
    input  logic [AXI_DATA_W-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    input  logic [AXI_ID_W-1:0]     m_rid,
    output logic                    m_rready,
    output logic                    m_awvalid,
    output logic [AXI_ADDR_W-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic [AXI_ID_W-1:0]     m_awid,
    output logic                    m_awlock,
    output logic [3:0]              m_awcache,
    output logic [2:0]              m_awprot,
    output logic [3:0]              m_awqos,
    output logic [3:0]              m_awregion,
    input  logic                    m_awready,
    output logic                    m_wvalid,
    output logic [AXI_DATA_W-1:0]   m_wdata,
    output logic [AXI_DATA_W/8-1:0] m_wstrb,
    output logic                    m_wlast,
    input  logic                    m_wready,
    input  logic                    m_bvalid,
    input  logic [1:0]              m_bresp,
    input  logic [AXI_ID_W-1:0]     m_bid,
    output logic                    m_bready,
    output logic                    wdog_err
);

    typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StW, StB} state_e;

    state_e state_q;
    logic   gnt_q;
    logic   rr_last_q;

    // Selected-master views of the request-side signals
    logic                    sel_arvalid, sel_awvalid, sel_wvalid, sel_wlast;
    logic                    sel_rready, sel_bready;
    logic [AXI_ADDR_W-1:0]   sel_araddr, sel_awaddr;
    logic [7:0]              sel_arlen, sel_awlen;
    logic [2:0]              sel_arsize, sel_awsize;
    logic [1:0]              sel_arburst, sel_awburst;
    logic [AXI_ID_W-1:0]     sel_arid, sel_awid;
    logic [AXI_DATA_W-1:0]   sel_wdata;
    logic [AXI_DATA_W/8-1:0] sel_wstrb;

    assign sel_arvalid = gnt_q ? s1_arvalid : s0_arvalid;
    assign sel_araddr  = gnt_q ? s1_araddr  : s0_araddr;
    assign sel_arlen   = gnt_q ? s1_arlen   : s0_arlen;
    assign sel_arsize  = gnt_q ? s1_arsize  : s0_arsize;
    assign sel_arburst = gnt_q ? s1_arburst : s0_arburst;
    assign sel_arid    = gnt_q ? s1_arid    : s0_arid;
    assign sel_awvalid = gnt_q ? s1_awvalid : s0_awvalid;
    assign sel_awaddr  = gnt_q ? s1_awaddr  : s0_awaddr;
    assign sel_awlen   = gnt_q ? s1_awlen   : s0_awlen;
    assign sel_awsize  = gnt_q ? s1_awsize  : s0_awsize;
    assign sel_awburst = gnt_q ? s1_awburst : s0_awburst;
    assign sel_awid    = gnt_q ? s1_awid    : s0_awid;
    assign sel_wvalid  = gnt_q ? s1_wvalid  : s0_wvalid;
    assign sel_wdata   = gnt_q ? s1_wdata   : s0_wdata;
    assign sel_wstrb   = gnt_q ? s1_wstrb   : s0_wstrb;
    assign sel_wlast   = gnt_q ? s1_wlast   : s0_wlast;
    assign sel_rready  = gnt_q ? s1_rready  : s0_rready;
    assign sel_bready  = gnt_q ? s1_bready  : s0_bready;

    assign m_arlock   = 1'b0;
    assign m_arcache  = 4'd0;
    assign m_arprot   = 3'd0;
    assign m_arqos    = 4'd0;
    assign m_arregion = 4'd0;
    assign m_awlock   = 1'b0;
    assign m_awcache  = 4'd0;
    assign m_awprot   = 3'd0;
    assign m_awqos    = 4'd0;
    assign m_awregion = 4'd0;

    // Routing; everything idles at 0 in StIdle and while rst is high
    always_comb begin
        m_arvalid  = 1'b0;
        m_araddr   = '0;
        m_arlen    = '0;
        m_arsize   = '0;
        m_arburst  = '0;
        m_arid     = '0;
        m_rready   = 1'b0;
        m_awvalid  = 1'b0;
        m_awaddr   = '0;
        m_awlen    = '0;
        m_awsize   = '0;
        m_awburst  = '0;
        m_awid     = '0;
        m_wvalid   = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_wlast    = 1'b0;
        m_bready   = 1'b0;
        s0_arready = 1'b0;
        s0_rvalid  = 1'b0;
        s0_rdata   = '0;
        s0_rresp   = '0;
        s0_rlast   = 1'b0;
        s0_rid     = '0;
        s0_awready = 1'b0;
        s0_wready  = 1'b0;
        s0_bvalid  = 1'b0;
        s0_bresp   = '0;
        s0_bid     = '0;
        s1_arready = 1'b0;
        s1_rvalid  = 1'b0;
        s1_rdata   = '0;
        s1_rresp   = '0;
        s1_rlast   = 1'b0;
        s1_rid     = '0;
        s1_awready = 1'b0;
        s1_wready  = 1'b0;
        s1_bvalid  = 1'b0;
        s1_bresp   = '0;
        s1_bid     = '0;
        if (!rst) begin
            unique case (state_q)
                StAr: begin
                    m_arvalid = sel_arvalid;
                    m_araddr  = sel_araddr;
                    m_arlen   = sel_arlen;
                    m_arsize  = sel_arsize;
                    m_arburst = sel_arburst;
                    m_arid    = sel_arid;
                    if (gnt_q) s1_arready = m_arready;
                    else       s0_arready = m_arready;
                end
                StR: begin
                    m_rready = sel_rready;
                    if (gnt_q) begin
                        s1_rvalid = m_rvalid;
                        s1_rdata  = m_rdata;
                        s1_rresp  = m_rresp;
                        s1_rlast  = m_rlast;
                        s1_rid    = m_rid;
                    end else begin
                        s0_rvalid = m_rvalid;
                        s0_rdata  = m_rdata;
                        s0_rresp  = m_rresp;
                        s0_rlast  = m_rlast;
                        s0_rid    = m_rid;
                    end
                end
                StAw: begin
                    m_awvalid = sel_awvalid;
                    m_awaddr  = sel_awaddr;
                    m_awlen   = sel_awlen;
                    m_awsize  = sel_awsize;
                    m_awburst = sel_awburst;
                    m_awid    = sel_awid;
                    if (gnt_q) s1_awready = m_awready;
                    else       s0_awready = m_awready;
                end
                StW: begin
                    m_wvalid = sel_wvalid;
                    m_wdata  = sel_wdata;
                    m_wstrb  = sel_wstrb;
                    m_wlast  = sel_wlast;
                    if (gnt_q) s1_wready = m_wready;
                    else       s0_wready = m_wready;
                end
                StB: begin
                    m_bready = sel_bready;
                    if (gnt_q) begin
                        s1_bvalid = m_bvalid;
                        s1_bresp  = m_bresp;
                        s1_bid    = m_bid;
                    end else begin
                        s0_bvalid = m_bvalid;
                        s0_bresp  = m_bresp;
                        s0_bid    = m_bid;
                    end
                end
                default: ;
            endcase
        end
    end

    // Handshakes can only fire in their own state because the routing above is state-gated
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = m_arvalid & m_arready;
    assign r_hs  = m_rvalid & m_rready;
    assign aw_hs = m_awvalid & m_awready;
    assign w_hs  = m_wvalid & m_wready;
    assign b_hs  = m_bvalid & m_bready;

    logic req0, req1, winner, win_rd;
    assign req0   = s0_arvalid | s0_awvalid;
    assign req1   = s1_arvalid | s1_awvalid;
    assign winner = (req0 & req1) ? ~rr_last_q : req1;
    assign win_rd = winner ? s1_arvalid : s0_arvalid;

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b0;
            rr_last_q <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req0 | req1) begin
                        gnt_q     <= winner;
                        rr_last_q <= winner;
                        state_q   <= win_rd ? StAr : StAw;
                    end
                end
                StAr:    if (ar_hs) state_q <= StR;
                StR:     if (r_hs && m_rlast) state_q <= StIdle;
                StAw:    if (aw_hs) state_q <= StW;
                StW:     if (w_hs && m_wlast) state_q <= StB;
                StB:     if (b_hs) state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef AXI_ARB_WDOG_EN
    logic [15:0] wdog_cnt_q;
    logic        wdog_err_q;
    logic        chan_hs;

    assign chan_hs = ar_hs | r_hs | aw_hs | w_hs | b_hs;

    // Flag fires on the increment that brings the count to WDOG_LIMIT
    always_ff @(posedge aclk) begin
        if (rst) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else if (state_q == StIdle || chan_hs) begin
            wdog_cnt_q <= '0;
        end else if (wdog_cnt_q != 16'hFFFF) begin
            wdog_cnt_q <= wdog_cnt_q + 16'd1;
            if ({16'd0, wdog_cnt_q} + 32'd1 >= WDOG_LIMIT) wdog_err_q <= 1'b1;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    // Limit only matters when the watchdog is built in
    assign wdog_err = 1'b0 & (WDOG_LIMIT != 0);
`endif

endmodule

// File: doc/axi_arb_2to1.md
Name: axi_arb_2to1

Overview:
- Two-master, one-slave AXI4 arbiter in front of the single-outstanding simulation SRAM model.
- s0 is the instruction fetch port and s1 is the load/store port; m is the slave side.
- Grants one whole transaction at a time: address phase, then data beats, then response. The grant is held until the transaction completes.
- Master selection is round-robin.

Parameters:
- AXI_ADDR_W, 64, address width
- AXI_ID_W, 8, ID width (IDs passed through unmodified)
- AXI_DATA_W, 64, data width
- WDOG_LIMIT, 1024, stall cycles before the watchdog fires (used only with the optional feature)

Ports:
- aclk  in  1  clock
- rst  in  1  synchronous reset, active-high
- sN_arvalid/araddr/arlen/arsize/arburst/arid  in  1/ADDR/8/3/2/ID  read address from master N (N=0,1)
- sN_arready  out  1
- sN_rvalid/rdata/rresp/rlast/rid  out  1/DATA/2/1/ID  read data to master N
- sN_rready  in  1
- sN_awvalid/awaddr/awlen/awsize/awburst/awid  in  1/ADDR/8/3/2/ID  write address from master N
- sN_awready  out  1
- sN_wvalid/wdata/wstrb/wlast  in  1/DATA/DATA/8/1
- sN_wready  out  1
- sN_bvalid/bresp/bid  out  1/2/ID
- sN_bready  in  1
- m_*  mirror of one sN_* set, directions inverted
- m_awlock/awcache/awprot/awqos/awregion and the m_ar* equivalents  out  1/4/3/4/4  driven constant 0
- wdog_err  out  1  sticky watchdog error flag

Behaviour:
- State machine states: IDLE, AR, R, AW, W, B. Registers: gnt (1 bit, master index) and rr_last (last master served).
- IDLE:
  - req0 = s0_arvalid|s0_awvalid; req1 = s1_arvalid|s1_awvalid.
  - Both requesting: winner = !rr_last. Only one requesting: that one wins.
  - Within the winning master, a read takes priority over a write.
  - Next cycle: gnt <= winner, rr_last <= winner, state <= AR or AW.
  - In IDLE all sN_*ready and m_*valid are 0. This gives a fixed 1-cycle arbitration bubble.
- AR: m_ar* = s[gnt]_ar* (combinational); s[gnt]_arready = m_arready. On handshake -> R.
- R: m_r* routed to s[gnt]; m_rready = s[gnt]_rready. On rvalid&rready&rlast -> IDLE.
- AW: same routing as AR, using the aw channel. On handshake -> W.
- W: s[gnt]_w* routed to m; m_wready routed back to s[gnt]. On wvalid&wready&wlast -> B.
- B: b channel routed to s[gnt]. On handshake -> IDLE.
- Non-granted master:
  - All its ready and valid outputs are held at 0.
  - Its data and ID outputs are 0.
  - Its pending valids are held and not dropped; AXI requires the master to keep them asserted.
- Simultaneous events:
  - If a master asserts arvalid and awvalid together, the read is served first. The write is re-arbitrated in the next IDLE.
  - With continuous requests from both masters, grants alternate 0,1,0,1.
- A granted master that drops its request after IDLE sampled it is a protocol violation. Behaviour in that case is undefined.
- Reset, including mid-transaction:
  - Next edge: state=IDLE, gnt=0, rr_last=1 (s0 wins the first contention), wdog_err=0.
  - All valid and ready outputs are 0 from the cycle after rst is sampled.
  - Outputs are 0 throughout reset.
- Burst length and IDs are not inspected. The beat count is governed by rlast and wlast only.

Optional Feature:
- Macro: AXI_ARB_WDOG_EN.
- With the macro defined:
  - A 16-bit counter clears in IDLE and on any handshake of the granted channel.
  - The counter increments in every other non-IDLE cycle.
  - When it reaches WDOG_LIMIT, wdog_err is set. wdog_err is sticky and clears only on rst.
  - The counter saturates.
  - The FSM continues unaffected.
- Without the macro: no counter is present and wdog_err is tied 0.

Test Plan:
- s0 read alone, arlen=3, araddr=0x8000_0000:
  - m_arvalid rises 1 cycle after s0_arvalid.
  - 4 beats are routed to s0; rlast occurs on the 4th beat.
  - FSM returns to IDLE; s1 outputs stay 0 throughout.
- s0 and s1 both assert arvalid in the first post-reset cycle:
  - s0 is granted first, then s1 after its rlast plus 1 IDLE cycle.
  - Then repeat both requests: s0 is granted first again (rr_last=1).
- s1 write, awlen=1, wstrb=0xFF then 0x0F:
  - Both beats are forwarded in order.
  - bvalid is routed to s1 with bid equal to awid=0x5A.
- s0 asserts arvalid and awvalid together:
  - The read completes fully before m_awvalid is asserted.
  - The write completes with bresp=0.
- rst asserted during the W state after beat 1 of 4:
  - Next cycle: all ready and valid outputs are 0 and state is IDLE.
  - A new s1 read after reset completes normally.
- With AXI_ARB_WDOG_EN and WDOG_LIMIT=16:
  - Hold m_rvalid=0 in R for 16 cycles: wdog_err=1 and stays 1 after the burst later completes.
  - Without the macro: wdog_err remains 0.
